duv_arb: RTL and testbench

DUV_ARB -- requirements
Module: duv_arb

---
 rtl/duv_arb_pkg.sv | 33 +++
 rtl/duv_arb.sv | 161 ++++++++++++++++
 tb/tb_duv_arb.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/duv_arb_pkg.sv
// duv_arb shared types: FSM state, owner id and round-robin pick.
// Imported by duv_arb; no ports.
package duv_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_e;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_e;

    localparam logic [7:0] CNT_MAX = 8'hFF;

    // Under contention the requester not served last wins.
    function automatic owner_e rr_pick(
        input logic [1:0] req,
        input owner_e     last
    );
        if (req == 2'b11) begin
            return (last == OWN_A) ? OWN_B : OWN_A;
        end
        return req[0] ? OWN_A : OWN_B;
    endfunction

    function automatic logic [1:0] own_onehot(input owner_e own);
        return (own == OWN_A) ? 2'b01 : 2'b10;
    endfunction

endpackage

// File: rtl/duv_arb.sv
// duv_arb: two-requester round-robin arbiter for a shared DUV.
// Ports: clk, arst (async, active-low), req/rel/a_din/b_din in;
// gnt (one-hot), duv_in_a/b, busy, tmo, gcnt_a/b out.
// Optional grant statistics: define DUV_ARB_STATS_EN.
module duv_arb
    import duv_arb_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 8,
    parameter int unsigned GAP      = 1
) (
    input  logic       clk,
    input  logic       arst,
    input  logic [1:0] req,
    input  logic [1:0] rel,
    input  logic [1:0] a_din,
    input  logic [1:0] b_din,
    output logic [1:0] gnt,
    output logic       duv_in_a,
    output logic       duv_in_b,
    output logic       busy,
    output logic       tmo,
    output logic [7:0] gcnt_a,
    output logic [7:0] gcnt_b
);

    localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);
    localparam logic [3:0] GAP_LIM  = 4'(GAP);

    state_e     state_q, state_d;
    owner_e     owner_q, owner_d;
    owner_e     last_q, last_d;
    owner_e     pick;
    logic [1:0] gnt_q, gnt_d;
    logic [7:0] hold_q, hold_d;
    logic [3:0] gap_q, gap_d;
    logic       tmo_q, tmo_d;
    logic [1:0] duv_q, duv_d;
    logic       own_req;
    logic       own_rel;
    logic       expire;

    assign pick    = rr_pick(req, last_q);
    assign own_req = (owner_q == OWN_A) ? req[0] : req[1];
    assign own_rel = (owner_q == OWN_A) ? rel[0] : rel[1];
    assign expire  = (hold_q == HOLD_LIM);

    // DUV drive is the owner's din delayed by one cycle behind gnt.
    always_comb begin
        duv_d = 2'b00;
        unique case (1'b1)
            gnt_q[0]: duv_d = a_din;
            gnt_q[1]: duv_d = b_din;
            default:  duv_d = 2'b00;
        endcase
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        hold_d  = hold_q;
        gap_d   = gap_q;
        tmo_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req != 2'b00) begin
                    state_d = S_GRANT;
                    owner_d = pick;
                    gnt_d   = own_onehot(pick);
                    // first granted cycle already counts as 1
                    hold_d  = 8'd1;
                end
            end
            S_GRANT: begin
                if (expire || !own_req || own_rel) begin
                    state_d = S_GAP;
                    gnt_d   = 2'b00;
                    last_d  = owner_q;
                    tmo_d   = expire;
                    gap_d   = 4'd1;
                end else if (hold_q != CNT_MAX) begin
                    hold_d = hold_q + 8'd1;
                end
            end
            S_GAP: begin
                if (gap_q >= GAP_LIM) begin
                    state_d = S_IDLE;
                    gap_d   = 4'd0;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q <= S_IDLE;
            owner_q <= OWN_B;
            last_q  <= OWN_B;
            gnt_q   <= 2'b00;
            hold_q  <= 8'd0;
            gap_q   <= 4'd0;
            tmo_q   <= 1'b0;
            duv_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
            tmo_q   <= tmo_d;
            duv_q   <= duv_d;
        end
    end

    assign gnt      = gnt_q;
    assign duv_in_a = duv_q[0];
    assign duv_in_b = duv_q[1];
    assign busy     = (state_q != S_IDLE);
    assign tmo      = tmo_q;

`ifdef DUV_ARB_STATS_EN
    logic       start_a;
    logic       start_b;
    logic [7:0] cnt_a_q;
    logic [7:0] cnt_b_q;

    assign start_a = (state_q == S_IDLE) && (req != 2'b00)
                     && (pick == OWN_A);
    assign start_b = (state_q == S_IDLE) && (req != 2'b00)
                     && (pick == OWN_B);

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            cnt_a_q <= 8'd0;
            cnt_b_q <= 8'd0;
        end else begin
            if (start_a && cnt_a_q != CNT_MAX) begin
                cnt_a_q <= cnt_a_q + 8'd1;
            end
            if (start_b && cnt_b_q != CNT_MAX) begin
                cnt_b_q <= cnt_b_q + 8'd1;
            end
        end
    end

    assign gcnt_a = cnt_a_q;
    assign gcnt_b = cnt_b_q;
`else
    assign gcnt_a = 8'd0;
    assign gcnt_b = 8'd0;
`endif

endmodule

// File: tb/tb_duv_arb.sv
// Self-checking bench for duv_arb: tenure-level model plus
// directed literal checks and randomized traffic.
module tb_duv_arb;

    localparam int HM = 4;
    localparam int GP = 1;
`ifdef DUV_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       arst  = 1'b0;
    logic [1:0] req   = 2'b00;
    logic [1:0] rel   = 2'b00;
    logic [1:0] a_din = 2'b00;
    logic [1:0] b_din = 2'b00;
    logic [1:0] gnt;
    logic       duv_in_a;
    logic       duv_in_b;
    logic       busy;
    logic       tmo;
    logic [7:0] gcnt_a;
    logic [7:0] gcnt_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    duv_arb #(.HOLD_MAX(HM), .GAP(GP)) dut (
        .clk      (clk),
        .arst     (arst),
        .req      (req),
        .rel      (rel),
        .a_din    (a_din),
        .b_din    (b_din),
        .gnt      (gnt),
        .duv_in_a (duv_in_a),
        .duv_in_b (duv_in_b),
        .busy     (busy),
        .tmo      (tmo),
        .gcnt_a   (gcnt_a),
        .gcnt_b   (gcnt_b)
    );

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Model: phase 0 = idle, 1 = someone holds the DUV, 2 = gap.
    int         m_phase, m_own, m_last, m_held, m_gap_left;
    int         m_cnt_a, m_cnt_b;
    logic [1:0] m_gnt, m_duv;
    logic       m_tmo;

    always @(posedge clk or negedge arst) begin
        if (!arst) begin
            m_phase = 0; m_own = 0; m_last = 1; m_held = 0;
            m_gap_left = 0; m_cnt_a = 0; m_cnt_b = 0;
            m_gnt = 2'b00; m_duv = 2'b00; m_tmo = 1'b0;
        end else begin
            if (m_gnt == 2'b01) m_duv = a_din;
            else if (m_gnt == 2'b10) m_duv = b_din;
            else m_duv = 2'b00;
            m_tmo = 1'b0;
            if (m_phase == 0) begin
                if (req != 2'b00) begin
                    if (req == 2'b11) m_own = 1 - m_last;
                    else m_own = req[0] ? 0 : 1;
                    m_phase = 1;
                    m_held  = 1;
                    m_gnt   = (m_own == 0) ? 2'b01 : 2'b10;
                    if (m_own == 0) m_cnt_a = (m_cnt_a < 255) ? m_cnt_a + 1 : 255;
                    else m_cnt_b = (m_cnt_b < 255) ? m_cnt_b + 1 : 255;
                end
            end else if (m_phase == 1) begin
                if (m_held == HM || !req[m_own] || rel[m_own]) begin
                    m_tmo      = (m_held == HM);
                    m_phase    = 2;
                    m_gap_left = GP;
                    m_last     = m_own;
                    m_gnt      = 2'b00;
                end else begin
                    m_held++;
                end
            end else begin
                m_gap_left--;
                if (m_gap_left == 0) m_phase = 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("cmp_gnt", 8'(gnt), 8'(m_gnt));
        chk("cmp_gnt_onehot", 8'(gnt == 2'b11), 8'd0);
        chk("cmp_duv_in_a", 8'(duv_in_a), 8'(m_duv[0]));
        chk("cmp_duv_in_b", 8'(duv_in_b), 8'(m_duv[1]));
        chk("cmp_busy", 8'(busy), 8'(m_phase != 0));
        chk("cmp_tmo", 8'(tmo), 8'(m_tmo));
        chk("cmp_gcnt_a", gcnt_a, STATS ? 8'(m_cnt_a) : 8'd0);
        chk("cmp_gcnt_b", gcnt_b, STATS ? 8'(m_cnt_b) : 8'd0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        arst = 1'b0;
        #2;
        chk("rst_gnt", 8'(gnt), 8'd0);
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_tmo", 8'(tmo), 8'd0);
        chk("rst_duv", 8'({duv_in_b, duv_in_a}), 8'd0);
        chk("rst_gcnt_a", gcnt_a, 8'd0);
        chk("rst_gcnt_b", gcnt_b, 8'd0);
        @(negedge clk);
        #1;
        arst = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        int ng;
        int nt;

        // single request, 1-cycle grant latency, DUV drive follows
        req = 2'b01; a_din = 2'b01; b_din = 2'b00;
        do_reset();
        tick(); chk("t034_gnt", 8'(gnt), 8'h01);
        chk("t034_duv_a_lag", 8'(duv_in_a), 8'd0);
        tick(); chk("t034_duv_a", 8'(duv_in_a), 8'd1);
        chk("t034_duv_b", 8'(duv_in_b), 8'd0);
        a_din = 2'b10;
        tick(); chk("t034_duv_ab", 8'({duv_in_b, duv_in_a}), 8'h2);
        req = 2'b00;
        tick(); chk("t034_drop", 8'(gnt), 8'h00);

        // contention alternates A, B, A
        req = 2'b11; a_din = 2'b00;
        do_reset();
        tick(); chk("t035_first_a", 8'(gnt), 8'h01);
        rel = 2'b01;
        tick(); rel = 2'b00;
        chk("t035_gap_gnt", 8'(gnt), 8'h00);
        chk("t035_gap_busy", 8'(busy), 8'd1);
        tick(); chk("t035_idle_busy", 8'(busy), 8'd0);
        tick(); chk("t035_then_b", 8'(gnt), 8'h02);
        rel = 2'b10;
        tick(); rel = 2'b00;
        tick(); tick();
        chk("t035_again_a", 8'(gnt), 8'h01);

        // expiry after HOLD_MAX cycles
        req = 2'b01;
        do_reset();
        ng = 0; nt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            ng += int'(gnt == 2'b01);
            nt += int'(tmo);
        end
        chk("t036_gnt_cycles", 8'(ng), 8'd4);
        chk("t036_tmo_pulses", 8'(nt), 8'd1);
        tick(); chk("t036_regrant", 8'(gnt), 8'h01);

        // non-owner release ignored
        req = 2'b01;
        do_reset();
        tick(); rel = 2'b10;
        tick(); chk("t037_keep", 8'(gnt), 8'h01);
        rel = 2'b01;
        tick(); rel = 2'b00;
        chk("t037_drop", 8'(gnt), 8'h00);
        chk("t037_no_tmo", 8'(tmo), 8'd0);

        // reset mid-tenure, pointer back to B
        req = 2'b01; a_din = 2'b01;
        do_reset();
        tick(); rel = 2'b01;
        tick(); rel = 2'b00;
        tick(); tick(); tick();
        chk("t038_pre_gnt", 8'(gnt), 8'h01);
        chk("t038_pre_duv", 8'(duv_in_a), 8'd1);
        #2; arst = 1'b0; req = 2'b11;
        #1;
        chk("t038_gnt", 8'(gnt), 8'h00);
        chk("t038_duv", 8'({duv_in_b, duv_in_a}), 8'd0);
        chk("t038_tmo", 8'(tmo), 8'd0);
        @(negedge clk); #1; arst = 1'b1;
        tick(); chk("t038_regrant_a", 8'(gnt), 8'h01);

        // 300 tenures of A saturate the statistic
        req = 2'b01; rel = 2'b00;
        do_reset();
        repeat (1800) tick();
        chk("t039_gcnt_a", gcnt_a, STATS ? 8'd255 : 8'd0);
        chk("t039_gcnt_b", gcnt_b, 8'd0);

        // randomized traffic with occasional async reset
        req = 2'b00;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            tick();
            req   = {1'($urandom_range(0, 9) < 8),
                     1'($urandom_range(0, 9) < 8)};
            rel   = {1'($urandom_range(0, 9) == 0),
                     1'($urandom_range(0, 9) == 0)};
            a_din = 2'($urandom);
            b_din = 2'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                #1; arst = 1'b0;
                #1; arst = 1'b1;
            end
        end

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
